// File: rtl/ps2_rx_fifo_pkg.sv
// Shared PS/2 receive definitions: deframer FSM states, byte width and the
// odd-parity helper used when the parity bit is sampled.
package ps2_rx_fifo_pkg;

  localparam int unsigned DataWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  // A PS/2 frame is good when data plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DataWidth-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Byte output bus of the PS/2 receiver towards the CPU peripheral side.
//  master (receiver): rx_data, rx_valid, fifo_count, parity_err, frame_err, overflow out; rx_ready in
//  slave  (consumer): the reverse
interface ps2_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [AW:0] fifo_count;
  logic        parity_err;
  logic        frame_err;
  logic        overflow;

  modport master (
    output rx_data, rx_valid, fifo_count, parity_err, frame_err, overflow,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, fifo_count, parity_err, frame_err, overflow,
    output rx_ready
  );

endinterface

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO.
//  clk, rst_n          clock, async active-low reset
//  push, push_data     write request and data
//  pop                 read request; ignored when empty
//  rd_data             head entry (0 while empty)
//  empty, count        status, count in 0..DEPTH
//  overflow            1-cycle pulse when a push is dropped because the FIFO is full
module ps2_rx_fifo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             overflow_q;
  logic             full, pop_ok, push_ok;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == FullCount);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      overflow_q <= push & ~push_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

  // Storage is not reset; mask it so the output reads 0 when nothing is held.
  assign rd_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with buffered byte output.
//  clk, rst_n          system clock, async active-low reset
//  ps2_clk, ps2_data   PS/2 lines, never driven by this block (always 'z)
//  bus (master)        rx_data/rx_valid/rx_ready byte handshake, fifo_count,
//                      parity_err/frame_err/overflow 1-cycle error pulses
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES  = 750,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  inout  wire            ps2_clk,
  inout  wire            ps2_data,
  ps2_rx_fifo_if.master  bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = $clog2(FILTER_CYCLES) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  assign ps2_clk  = 1'bz;
  assign ps2_data = 1'bz;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] filt_cnt_q;
  logic          strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_prev_q <= filt_q;
      // A new clock level is only taken once it has held for FILTER_CYCLES.
      if (clk_s2_q != filt_q) begin
        if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) begin
          filt_q     <= clk_s2_q;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  assign strobe = filt_prev_q & ~filt_q;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          push_q, push_d;
  logic          par_err_q, par_err_d;
  logic          frame_err_q, frame_err_d;
  logic          timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      push_q      <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      push_q      <= push_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign timeout = (state_q != StIdle) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    push_d      = 1'b0;
    par_err_d   = 1'b0;
    frame_err_d = 1'b0;
    to_cnt_d    = (state_q == StIdle || strobe) ? '0 : to_cnt_q + 1'b1;

    // Timeout wins over a coincident strobe; the partial byte is dropped.
    if (timeout) begin
      state_d     = StIdle;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end else if (strobe) begin
      unique case (state_q)
        StIdle: begin
          // A 1 here is a mid-frame resync, not a start bit.
          if (!dat_s2_q) begin
            state_d   = StData;
            bit_idx_d = '0;
            shift_d   = '0;
          end
        end
        StData: begin
          shift_d[bit_idx_q] = dat_s2_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_ok_d = odd_parity_ok(shift_q, dat_s2_q);
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!dat_s2_q)      frame_err_d = 1'b1;
          else if (!par_ok_q) par_err_d   = 1'b1;
          else                push_d      = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        fifo_overflow;

  // shift_q is stable in StIdle until the next start strobe, so it is safe to push a cycle late.
  ps2_rx_fifo_sync_fifo #(
    .WIDTH (DataWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (bus.rx_ready),
    .rd_data   (fifo_rd_data),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_overflow)
  );

  assign bus.rx_data    = fifo_rd_data;
  assign bus.rx_valid   = ~fifo_empty;
  assign bus.fifo_count = fifo_count;
  assign bus.parity_err = par_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = fifo_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: PS/2 frames are bit-banged, the expected
// byte stream and error counts come from a queue-based model of the frame rules.
module tb_ps2_rx_fifo;

  localparam int unsigned FC = 4;
  localparam int unsigned TC = 200;
  localparam int unsigned FD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ps2_clk_drv = 1'b1;
  logic ps2_data_drv = 1'b1;
  wire  ps2_clk_w;
  wire  ps2_data_w;
  assign ps2_clk_w  = ps2_clk_drv;
  assign ps2_data_w = ps2_data_drv;

  ps2_rx_fifo_if #(.FIFO_DEPTH(FD)) bus ();

  ps2_rx_fifo #(
    .FILTER_CYCLES  (FC),
    .TIMEOUT_CYCLES (TC),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk_w),
    .ps2_data (ps2_data_w),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] model_q[$];
  int exp_par = 0, exp_frame = 0, exp_ovf = 0;
  int obs_par = 0, obs_frame = 0, obs_ovf = 0;
  int last_fe_cyc = 0;
  int last_edge_cyc = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared with the model head; error pulses are tallied.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid && bus.rx_ready) begin
        if (model_q.size() == 0) begin
          check("pop_unexpected_model_size", model_q.size(), 1);
        end else begin
          logic [7:0] e;
          e = model_q.pop_front();
          check("rx_data", {24'd0, bus.rx_data}, {24'd0, e});
        end
      end
      if (bus.parity_err) obs_par++;
      if (bus.frame_err) begin
        obs_frame++;
        last_fe_cyc = cyc;
      end
      if (bus.overflow) obs_ovf++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 bus.rx_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One PS/2 bit: data set during clock high, device drops the clock for 20 cycles.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data_drv = b;
    if (glitch) begin
      tick(8);
      ps2_clk_drv = 1'b0;
      tick(2);
      ps2_clk_drv = 1'b1;
      tick(10);
    end else begin
      tick(20);
    end
    ps2_clk_drv   = 1'b0;
    last_edge_cyc = cyc;
    tick(20);
    ps2_clk_drv = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input logic stop,
                            input int glitch_at, input bit pop_at_push);
    logic [9:0] bits;
    bits = {(~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i], i == glitch_at);
    ps2_data_drv = stop;
    tick(20);
    ps2_clk_drv = 1'b0;
    tick(3);
    // Reference model of the frame outcome.
    if (stop == 1'b0)                               exp_frame++;
    else if (par_flip)                              exp_par++;
    else if (model_q.size() >= FD && !pop_at_push)  exp_ovf++;
    else                                            model_q.push_back(d);
    if (pop_at_push) begin
      // Pop lands in the push cycle: 2 sync + FC filter cycles to the strobe, push one later.
      tick(4);
      bus.rx_ready = 1'b1;
      tick(1);
      bus.rx_ready = 1'b0;
      tick(12);
    end else begin
      tick(17);
    end
    ps2_clk_drv  = 1'b1;
    ps2_data_drv = 1'b1;
    tick(40);
  endtask

  task automatic pop_one();
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    tick(1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_valid"}, {31'd0, bus.rx_valid}, 0);
    check({tag, "_rx_data"}, {24'd0, bus.rx_data}, 0);
    check({tag, "_count"}, {29'd0, bus.fifo_count}, 0);
    check({tag, "_err_pulses"}, {29'd0, bus.parity_err, bus.frame_err, bus.overflow}, 0);
  endtask

  initial begin
    int dt;
    bus.rx_ready = 1'b0;
    tick(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(5);
    check_idle_outputs("post_reset");

    // Basic receive and pop.
    send_frame(8'h1C, 0, 1'b1, -1, 0);
    check("t1_rx_valid", {31'd0, bus.rx_valid}, 1);
    check("t1_rx_data", {24'd0, bus.rx_data}, 32'h1C);
    check("t1_count", {29'd0, bus.fifo_count}, 1);
    pop_one();
    check("t1_count_after_pop", {29'd0, bus.fifo_count}, 0);

    // Parity error then good frame.
    send_frame(8'hF0, 1, 1'b1, -1, 0);
    check("t2_parity_err_pulses", obs_par, exp_par);
    check("t2_count", {29'd0, bus.fifo_count}, 0);
    send_frame(8'h1C, 0, 1'b1, -1, 0);
    check("t2_count_good", {29'd0, bus.fifo_count}, 1);
    pop_one();

    // Glitches on ps2_clk, idle (with data low) and mid-frame.
    ps2_data_drv = 1'b0;
    tick(5);
    ps2_clk_drv = 1'b0;
    tick(2);
    ps2_clk_drv = 1'b1;
    tick(10);
    ps2_data_drv = 1'b1;
    tick(20);
    send_frame(8'h5A, 0, 1'b1, 4, 0);
    check("t3_count", {29'd0, bus.fifo_count}, 1);
    pop_one();
    check("t3_no_errors", obs_par + obs_frame, exp_par + exp_frame);

    // Timeout after start + 5 data bits.
    send_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 0);
    exp_frame++;
    tick(280);
    check("t4_frame_err_pulses", obs_frame, exp_frame);
    dt = last_fe_cyc - last_edge_cyc;
    check("t4_timeout_latency_in_200_215", {31'd0, (dt >= 200 && dt <= 215)}, 1);
    send_frame(8'h29, 0, 1'b1, -1, 0);
    check("t4_count", {29'd0, bus.fifo_count}, 1);
    pop_one();

    // Overflow with rx_ready held low.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1'b1, -1, 0);
    check("t5_count_full", {29'd0, bus.fifo_count}, FD);
    check("t5_overflow_pulses", obs_ovf, exp_ovf);
    for (int i = 0; i < 4; i++) begin
      pop_one();
      tick(1);
    end
    check("t5_count_drained", {29'd0, bus.fifo_count}, 0);

    // Push and pop together while full.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 0, 1'b1, -1, 0);
    send_frame(8'h14, 0, 1'b1, -1, 1);
    check("t6_count_stays_full", {29'd0, bus.fifo_count}, FD);
    check("t6_no_new_overflow", obs_ovf, exp_ovf);
    for (int i = 0; i < 4; i++) begin
      pop_one();
      tick(1);
    end

    // Random bytes, random parity/stop faults, random consumer stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      int r;
      d = 8'($urandom);
      r = int'($urandom_range(0, 7));
      send_frame(d, r < 2, (r == 2) ? 1'b0 : 1'b1, -1, 0);
    end
    rand_ready = 1'b0;
    tick(2);
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 50 && model_q.size() != 0; i++) tick(1);
    bus.rx_ready = 1'b0;
    tick(1);
    check("t7_model_drained", model_q.size(), 0);
    check("t7_parity_err_pulses", obs_par, exp_par);
    check("t7_frame_err_pulses", obs_frame, exp_frame);
    check("t7_overflow_pulses", obs_ovf, exp_ovf);

    // Reset mid-frame with bytes buffered.
    send_frame(8'h44, 0, 1'b1, -1, 0);
    send_frame(8'h55, 0, 1'b1, -1, 0);
    check("t8_count_before_reset", {29'd0, bus.fifo_count}, 2);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    ps2_clk_drv  = 1'b0;
    tick(5);
    rst_n = 1'b0;
    #2;
    check_idle_outputs("t8_in_reset");
    model_q.delete();
    ps2_clk_drv  = 1'b1;
    ps2_data_drv = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(40);
    send_frame(8'h33, 0, 1'b1, -1, 0);
    check("t8_count_after_reset", {29'd0, bus.fifo_count}, 1);
    pop_one();
    check("t8_model_drained", model_q.size(), 0);
    check("t8_frame_err_pulses", obs_frame, exp_frame);
    check("t8_parity_err_pulses", obs_par, exp_par);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
